// File: rtl/btn_bounce_gen.sv
// Bouncy-pushbutton emitter: each accepted start produces a pseudo-random press bounce,
// a stable hold, a release bounce and a quiet gap on btn_out, then pulses done.
module btn_bounce_gen #(
  parameter int unsigned BOUNCE_EDGES = 8,
  parameter int unsigned MIN_GLITCH   = 2,
  parameter int unsigned GLITCH_LOG2  = 4,
  parameter int unsigned HOLD_CYCLES  = 300,
  parameter int unsigned RELEASE_GAP  = 150,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       btn_out,
  output logic       done,
  output logic [3:0] press_count
);

  localparam int unsigned RAND_MAX = MIN_GLITCH + (2 ** GLITCH_LOG2) - 1;
  localparam int unsigned HG_MAX   = (HOLD_CYCLES > RELEASE_GAP) ? HOLD_CYCLES : RELEASE_GAP;
  localparam int unsigned MAX_LEN  = (HG_MAX > RAND_MAX) ? HG_MAX : RAND_MAX;
  localparam int unsigned CW       = $clog2(MAX_LEN + 1);
  localparam int unsigned HW       = $clog2(BOUNCE_EDGES + 1);
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [HW-1:0] HI_LAST   = HW'(BOUNCE_EDGES);
  localparam logic [HW-1:0] HI_GLITCH = HW'(BOUNCE_EDGES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;
  typedef enum logic [1:0] {LEN_RAND, LEN_HOLD, LEN_GAP} len_sel_t;

  state_t        state, state_nx;
  len_sel_t      len_sel;
  logic [CW-1:0] cnt, len_m1;
  logic [HW-1:0] hi_cnt, hi_nx;
  logic [15:0]   lfsr, lfsr_nx;
  logic          seg_end, load, load_lvl, fin;

  assign seg_end = (cnt == '0);

  // State register
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; hi_cnt counts high segments in PRESS, glitch highs in RELEASE
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PRESS;
      PRESS:   if (seg_end && btn_out && (hi_cnt == HI_LAST)) state_nx = RELEASE;
      RELEASE: if (seg_end && !btn_out && (hi_cnt == HI_GLITCH)) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / segment-load control
  always_comb begin
    ready    = (state == IDLE);
    busy     = ~ready;
    load     = 1'b0;
    load_lvl = 1'b0;
    fin      = 1'b0;
    hi_nx    = hi_cnt;
    len_sel  = LEN_RAND;
    case (state)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          load_lvl = 1'b1;
          hi_nx    = HW'(1);
          len_sel  = (hi_nx == HI_LAST) ? LEN_HOLD : LEN_RAND;
        end
      end
      PRESS: begin
        if (seg_end) begin
          load = 1'b1;
          if (btn_out) begin
            load_lvl = 1'b0;
            if (hi_cnt == HI_LAST) begin
              hi_nx   = '0;
              len_sel = (hi_nx == HI_GLITCH) ? LEN_GAP : LEN_RAND;
            end
          end else begin
            load_lvl = 1'b1;
            hi_nx    = hi_cnt + HW'(1);
            len_sel  = (hi_nx == HI_LAST) ? LEN_HOLD : LEN_RAND;
          end
        end
      end
      RELEASE: begin
        if (seg_end) begin
          if (!btn_out) begin
            if (hi_cnt == HI_GLITCH) begin
              fin = 1'b1;
            end else begin
              load     = 1'b1;
              load_lvl = 1'b1;
              hi_nx    = hi_cnt + HW'(1);
            end
          end else begin
            load     = 1'b1;
            load_lvl = 1'b0;
            len_sel  = (hi_cnt == HI_GLITCH) ? LEN_GAP : LEN_RAND;
          end
        end
      end
      default: ;
    endcase
  end

  // Segment length minus one, taken from the lfsr value current at load time
  always_comb begin
    case (len_sel)
      LEN_HOLD: len_m1 = CW'(HOLD_CYCLES - 1);
      LEN_GAP:  len_m1 = CW'(RELEASE_GAP - 1);
      default:  len_m1 = CW'(MIN_GLITCH - 1) + CW'(lfsr[GLITCH_LOG2-1:0]);
    endcase
  end

  assign lfsr_nx = lfsr[0] ? ((lfsr >> 1) ^ LFSR_MASK) : (lfsr >> 1);

  // Datapath: segment countdown, level, lfsr, completion bookkeeping
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      btn_out     <= 1'b0;
      done        <= 1'b0;
      press_count <= 4'd0;
      lfsr        <= SEED;
      cnt         <= '0;
      hi_cnt      <= '0;
    end else begin
      done <= fin;
      if (fin) begin
        press_count <= press_count + 4'd1;
        btn_out     <= 1'b0;
        hi_cnt      <= '0;
      end else if (load) begin
        btn_out <= load_lvl;
        cnt     <= len_m1;
        lfsr    <= lfsr_nx;
        hi_cnt  <= hi_nx;
      end else if (!seg_end) begin
        cnt <= cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_btn_bounce_gen.sv
// Directed bench for btn_bounce_gen: segment lengths are compared with a reference
// lfsr sequence; covers reset, ignored starts, back-to-back runs, mid-run reset and BOUNCE_EDGES=1.
module tb_btn_bounce_gen;

  logic       sysclk, reset, start, start1;
  logic       ready, busy, btn_out, done;
  logic       ready1, busy1, btn1, done1;
  logic [3:0] press_count, press_count1;

  int n_checks, n_err;
  int exp_len[0:29];
  int segs[0:63];
  int n_seg;
  bit got_done;

  btn_bounce_gen #(
    .BOUNCE_EDGES(8), .MIN_GLITCH(2), .GLITCH_LOG2(4),
    .HOLD_CYCLES(300), .RELEASE_GAP(150), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .sysclk(sysclk), .reset(reset), .start(start), .ready(ready), .busy(busy),
    .btn_out(btn_out), .done(done), .press_count(press_count)
  );

  btn_bounce_gen #(
    .BOUNCE_EDGES(1), .MIN_GLITCH(2), .GLITCH_LOG2(4),
    .HOLD_CYCLES(300), .RELEASE_GAP(150), .LFSR_SEED(16'hACE1)
  ) u_dut1 (
    .sysclk(sysclk), .reset(reset), .start(start1), .ready(ready1), .busy(busy1),
    .btn_out(btn1), .done(done1), .press_count(press_count1)
  );

  always #5 sysclk = ~sysclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: H,L alternating for 15 press segments (index 14 is the hold),
  // then L,H alternating for 15 release segments (index 29 is the gap).
  task automatic build_model();
    logic [15:0] l;
    l = 16'hACE1;
    for (int i = 0; i < 30; i++) begin
      if (i == 14)      exp_len[i] = 300;
      else if (i == 29) exp_len[i] = 150;
      else              exp_len[i] = 2 + int'(l[3:0]);
      l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    end
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    start  = 1'b0;
    start1 = 1'b0;
    reset  = 1'b0;
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
  endtask

  // Launch one run and record run lengths of btn_out until done is seen
  task automatic run_seq(input bit spam);
    logic cur;
    int   len;
    n_seg    = 0;
    cur      = 1'b1;
    len      = 0;
    got_done = 1'b0;
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    for (int c = 0; c < 5000 && !got_done; c++) begin
      if (done) begin
        got_done = 1'b1;
        if (n_seg < 64) segs[n_seg] = len;
        n_seg++;
      end else if (btn_out == cur) begin
        len++;
      end else begin
        if (n_seg < 64) segs[n_seg] = len;
        n_seg++;
        cur = btn_out;
        len = 1;
      end
      start = got_done ? 1'b0 : spam;
      if (!got_done) @(negedge sysclk);
    end
    start = 1'b0;
    check("run_done_seen", 32'(got_done), 32'd1);
  endtask

  task automatic compare_run(input string tag);
    int bad;
    bad = 0;
    check({tag, "_nseg"}, 32'(n_seg), 32'd30);
    for (int i = 0; i < 30; i++) begin
      check($sformatf("%s_seg%0d", tag, i), 32'(segs[i]), 32'(exp_len[i]));
      if (i != 14 && i != 29 && (segs[i] < 2 || segs[i] > 17)) bad++;
    end
    check({tag, "_range"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int highs, rises, runs, hi, lo;
    logic prev;
    bit got;
    n_checks = 0;
    n_err    = 0;
    sysclk   = 1'b0;
    reset    = 1'b0;
    start    = 1'b1;
    start1   = 1'b1;
    build_model();

    // 1: reset held with start high, then idle
    repeat (3) @(negedge sysclk);
    check("t1_btn", 32'(btn_out), 32'd0);
    check("t1_done", 32'(done), 32'd0);
    check("t1_cnt", 32'(press_count), 32'd0);
    check("t1_ready", 32'(ready), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    start  = 1'b0;
    start1 = 1'b0;
    @(negedge sysclk);
    reset = 1'b1;
    highs = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge sysclk);
      if (btn_out || done) highs++;
    end
    check("t1_quiet", 32'(highs), 32'd0);

    // 2: single start pulse
    do_reset();
    run_seq(1'b0);
    compare_run("t2");
    check("t2_cnt", 32'(press_count), 32'd1);
    @(negedge sysclk);
    check("t2_done_1cyc", 32'(done), 32'd0);
    check("t2_ready", 32'(ready), 32'd1);

    // 3: start spammed during the run
    do_reset();
    run_seq(1'b1);
    compare_run("t3");
    check("t3_cnt", 32'(press_count), 32'd1);
    @(negedge sysclk);
    check("t3_idle", 32'(ready), 32'd1);

    // 5: reset in the middle of the hold segment
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    rises = 1;
    prev  = btn_out;
    for (int c = 0; c < 2000 && rises < 8; c++) begin
      @(negedge sysclk);
      if (btn_out && !prev) rises++;
      prev = btn_out;
    end
    repeat (50) @(negedge sysclk);
    check("t5_in_hold", 32'(btn_out), 32'd1);
    check("t5_cnt_before", 32'(press_count), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t5_btn_drop", 32'(btn_out), 32'd0);
    check("t5_cnt_clear", 32'(press_count), 32'd0);
    check("t5_ready", 32'(ready), 32'd1);
    highs = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge sysclk);
      if (done) highs++;
    end
    check("t5_no_done", 32'(highs), 32'd0);
    reset = 1'b1;
    run_seq(1'b0);
    compare_run("t5");

    // 4: start held high for 16 back-to-back runs
    do_reset();
    start = 1'b1;
    runs  = 0;
    for (int c = 0; c < 20000 && runs < 16; c++) begin
      @(negedge sysclk);
      if (done) begin
        runs++;
        check($sformatf("t4_cnt%0d", runs), 32'(press_count), 32'(runs % 16));
        @(negedge sysclk);
        check($sformatf("t4_restart%0d", runs), 32'(btn_out), 32'd1);
      end
    end
    start = 1'b0;
    check("t4_runs", 32'(runs), 32'd16);
    check("t4_wrap", 32'(press_count), 32'd0);

    // 6: BOUNCE_EDGES=1 gives one clean pulse
    do_reset();
    start1 = 1'b1;
    @(negedge sysclk);
    start1 = 1'b0;
    hi  = 0;
    lo  = 0;
    got = 1'b0;
    for (int c = 0; c < 1000 && !got; c++) begin
      if (done1) got = 1'b1;
      else if (btn1) hi++;
      else lo++;
      if (!got) @(negedge sysclk);
    end
    check("t6_done", 32'(got), 32'd1);
    check("t6_high", 32'(hi), 32'd300);
    check("t6_low", 32'(lo), 32'd150);
    check("t6_cnt", 32'(press_count1), 32'd1);
    @(negedge sysclk);
    check("t6_done_1cyc", 32'(done1), 32'd0);
    check("t6_ready", 32'(ready1), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
